mux_rr_arbiter: RTL and testbench

Shares a single N-to-1 data mux between N requesters, each using valid/ready handshakes. A round-robin arbiter drives the mux select. The winner's data is captured into a one-entry output register, which presents valid/ready to one downstream consumer. The block sits between several producer blocks and one shared sink.

---
 rtl/mux_arb_pkg.sv | 15 +
 rtl/rr_picker.sv | 31 +++
 rtl/mux_rr_arbiter.sv | 70 +++++++
 tb/tb_mux_rr_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared helpers for the round-robin mux arbiter: pointer advance and
// source-index width derivation.
package mux_arb_pkg;

  // Width of a source index for n requesters (at least one bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Next position after ptr in a ring of n entries; exact for any n.
  function automatic int rr_next(input int ptr, input int n);
    return (ptr + 1) % n;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: returns the first valid requester
// found after the last-grant pointer, wrapping modulo N.
module rr_picker
  import mux_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     req_valid,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] winner
);

  logic [IDX_W-1:0] cand;

  // Scan ptr+1 .. ptr+N (mod N); the first valid entry wins.
  always_comb begin
    any    = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 0; k < N; k++) begin
      cand = IDX_W'((rr_next(int'(ptr), N) + k) % N);
      if (!any && req_valid[cand]) begin
        any    = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// N-to-1 shared data mux with round-robin arbitration feeding a one-entry
// output register with a valid/ready handshake toward a single sink.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8,
  localparam int IDX_W = idx_w(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_valid,
  input  logic [N*W-1:0]   req_data,
  output logic [N-1:0]     req_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [IDX_W-1:0] out_src,
  input  logic             out_ready
);

  logic [IDX_W-1:0] ptr_p1;
  logic [IDX_W-1:0] src_p1;
  logic [W-1:0]     data_p1;
  logic             vld_p1;

  logic             any;
  logic             load;
  logic [IDX_W-1:0] winner;
  logic [W-1:0]     win_data;

  rr_picker #(.N(N)) u_picker (
    .req_valid (req_valid),
    .ptr       (ptr_p1),
    .any       (any),
    .winner    (winner)
  );

  // Accept when something is requesting and the output slot is free or
  // draining this cycle; held off entirely while reset is asserted.
  assign load     = rst_n && any && (!vld_p1 || out_ready);
  assign win_data = req_data[int'(winner)*W +: W];

  // One-hot accept to the winner only on a load cycle.
  always_comb begin
    req_ready = '0;
    if (load) req_ready[winner] = 1'b1;
  end

  // Stage p1: output register and last-grant pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      src_p1  <= '0;
      ptr_p1  <= IDX_W'(N - 1);
    end else if (load) begin
      vld_p1  <= 1'b1;
      data_p1 <= win_data;
      src_p1  <= winner;
      ptr_p1  <= winner;
    end else if (vld_p1 && out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_src   = src_p1;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: a 4-requester instance and a
// 3-requester instance for non-power-of-2 wrap.
module tb_mux_rr_arbiter;

  logic        clk;
  logic        rst_n;

  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_src;
  logic        out_ready;

  logic [2:0]  b_req_valid;
  logic [23:0] b_req_data;
  logic [2:0]  b_req_ready;
  logic        b_out_valid;
  logic [7:0]  b_out_data;
  logic [1:0]  b_out_src;
  logic        b_out_ready;

  int n_checks = 0;
  int n_err    = 0;

  logic [3:0]  pend;
  logic [31:0] held;

  mux_rr_arbiter #(.N(4), .W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  mux_rr_arbiter #(.N(3), .W(8)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (b_req_valid),
    .req_data  (b_req_data),
    .req_ready (b_req_ready),
    .out_valid (b_out_valid),
    .out_data  (b_out_data),
    .out_src   (b_out_src),
    .out_ready (b_out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Requester protocol: a pending request must keep valid and data stable.
  always @(posedge clk) begin
    if (!rst_n) begin
      pend = '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (pend[i]) begin
          chk("hold_valid", {31'd0, req_valid[i]}, 32'd1);
          chk("hold_data", {24'd0, req_data[i*8 +: 8]}, {24'd0, held[i*8 +: 8]});
        end
      end
      pend = req_valid & ~req_ready;
      held = req_data;
    end
  end

  initial begin
    rst_n       = 1'b0;
    req_valid   = 4'b1111;
    req_data    = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    out_ready   = 1'b1;
    b_req_valid = 3'b000;
    b_req_data  = {8'hB2, 8'hB1, 8'hB0};
    b_out_ready = 1'b1;

    // Reset held across a clock edge with all requesters valid
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_out_src", {30'd0, out_src}, 32'd0);
    chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_b_out_valid", {31'd0, b_out_valid}, 32'd0);
    rst_n = 1'b1;

    // All valid: rotation 0,1,2,3 then each drops after its second grant
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rot_ready", {28'd0, req_ready}, 32'd1 << (k % 4));
      tick();
      chk("rot_valid", {31'd0, out_valid}, 32'd1);
      chk("rot_src", {30'd0, out_src}, k % 4);
      chk("rot_data", {24'd0, out_data}, 32'hA0 + (k % 4));
      if (k >= 4) req_valid[k % 4] = 1'b0;
    end

    // Single requester 2 granted back to back
    req_valid = 4'b0100;
    for (int j = 0; j < 5; j++) begin
      req_data[23:16] = 8'h50 + 8'(j);
      #1;
      chk("single_ready", {28'd0, req_ready}, 32'h4);
      tick();
      chk("single_valid", {31'd0, out_valid}, 32'd1);
      chk("single_src", {30'd0, out_src}, 32'd2);
      chk("single_data", {24'd0, out_data}, 32'h50 + j);
    end
    req_valid = 4'b0000;

    // Put the pointer on 1
    req_valid      = 4'b0010;
    req_data[15:8] = 8'h11;
    #1;
    chk("p1_ready", {28'd0, req_ready}, 32'h2);
    tick();
    chk("p1_src", {30'd0, out_src}, 32'd1);
    chk("p1_data", {24'd0, out_data}, 32'h11);

    // Backpressure with requesters 1 and 3 waiting
    req_data[15:8]  = 8'h21;
    req_data[31:24] = 8'h33;
    req_valid       = 4'b1010;
    out_ready       = 1'b0;
    for (int j = 0; j < 4; j++) begin
      #1;
      chk("stall_ready", {28'd0, req_ready}, 32'd0);
      tick();
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_src", {30'd0, out_src}, 32'd1);
      chk("stall_data", {24'd0, out_data}, 32'h11);
    end
    out_ready = 1'b1;
    #1;
    chk("release_ready", {28'd0, req_ready}, 32'h8);
    tick();
    chk("release_src", {30'd0, out_src}, 32'd3);
    chk("release_data", {24'd0, out_data}, 32'h33);
    req_valid[3] = 1'b0;
    #1;
    chk("next_ready", {28'd0, req_ready}, 32'h2);
    tick();
    chk("next_src", {30'd0, out_src}, 32'd1);
    chk("next_data", {24'd0, out_data}, 32'h21);
    req_valid = 4'b0000;

    // No requests: only the drain happens
    #1;
    chk("idle_ready", {28'd0, req_ready}, 32'd0);
    tick();
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_src", {30'd0, out_src}, 32'd1);
    chk("drain_data", {24'd0, out_data}, 32'h21);

    // Pointer 1 searches 2,3,0
    req_valid     = 4'b0001;
    req_data[7:0] = 8'h44;
    #1;
    chk("wrap_ready", {28'd0, req_ready}, 32'h1);
    tick();
    chk("wrap_src", {30'd0, out_src}, 32'd0);
    chk("wrap_data", {24'd0, out_data}, 32'h44);

    // Stall with requester 2 pending, then asynchronous reset mid-cycle
    req_valid       = 4'b0100;
    req_data[23:16] = 8'h66;
    out_ready       = 1'b0;
    #1;
    chk("pre_arst_ready", {28'd0, req_ready}, 32'd0);
    chk("pre_arst_valid", {31'd0, out_valid}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_data", {24'd0, out_data}, 32'd0);
    chk("arst_ready", {28'd0, req_ready}, 32'd0);
    req_valid[0]  = 1'b1;
    req_data[7:0] = 8'h77;
    tick();
    chk("arst_hold_valid", {31'd0, out_valid}, 32'd0);
    #2;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("post_arst_ready", {28'd0, req_ready}, 32'h1);
    tick();
    chk("post_arst_src", {30'd0, out_src}, 32'd0);
    chk("post_arst_data", {24'd0, out_data}, 32'h77);
    req_valid[0] = 1'b0;
    #1;
    chk("post_arst_ready2", {28'd0, req_ready}, 32'h4);
    tick();
    chk("post_arst_src2", {30'd0, out_src}, 32'd2);
    chk("post_arst_data2", {24'd0, out_data}, 32'h66);
    req_valid = 4'b0000;

    // Three requesters: pointer 2 with 0 and 2 valid gives 0,2,0
    b_req_valid = 3'b101;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("n3_ready", {29'd0, b_req_ready}, (k == 1) ? 32'h4 : 32'h1);
      tick();
      chk("n3_valid", {31'd0, b_out_valid}, 32'd1);
      chk("n3_src", {30'd0, b_out_src}, (k == 1) ? 32'd2 : 32'd0);
      chk("n3_data", {24'd0, b_out_data}, (k == 1) ? 32'hB2 : 32'hB0);
    end
    b_req_valid = 3'b000;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
